// File: rtl/game_pkg.sv
// Shared shooter-datapath definitions: screen geometry, bullet FSM states,
// default movement rate and a saturating subtract used for spawn clamping.
package game_pkg;

  localparam int SCREEN_W         = 640;
  localparam int SCREEN_H         = 480;
  localparam int STEP_DIV_DEFAULT = 250_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } bullet_state_t;

  // a - b floored at zero, so a spawn near the top edge never wraps.
  function automatic logic [9:0] sat_sub10(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? 10'd0 : (a - b);
  endfunction

endpackage

// File: rtl/player_bullet_ctrl_if.sv
// Player bullet bus: fire/plane/hit inputs from the game, bullet position and
// status toward the collision judge.
interface player_bullet_ctrl_if;
  logic       fire;
  logic [9:0] plane_x;
  logic [9:0] plane_y;
  logic       hit;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic       mybullet_en;
  logic       shot;

  modport master (
    output fire, plane_x, plane_y, hit,
    input  b_x, b_y, mybullet_en, shot
  );

  modport slave (
    input  fire, plane_x, plane_y, hit,
    output b_x, b_y, mybullet_en, shot
  );
endinterface

// File: rtl/player_bullet_ctrl_step_ticker.sv
// Enable-gated clock divider: wraps every DIV cycles and flags the wrap cycle.
// Held at zero while disabled so the first tick lands DIV cycles after enable.
module step_ticker import game_pkg::*; #(
  parameter int DIV = STEP_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CLOG_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W  = (CLOG_W > 18) ? CLOG_W : 18;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == LP_LAST);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/player_bullet_ctrl.sv
// Single player bullet: launch on a fire edge, climb at a fixed step rate,
// retire on hit or top-of-screen exit, then enforce a step-counted cooldown.
module player_bullet_ctrl import game_pkg::*; #(
  parameter int STEP_DIV = STEP_DIV_DEFAULT,
  parameter int SPEED    = 4,
  parameter int X_OFF    = 14,
  parameter int Y_OFF    = 16,
  parameter int COOLDOWN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  player_bullet_ctrl_if.slave  bus
);

  localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [COOL_W-1:0] LP_COOL_LAST = COOL_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [9:0] LP_SPEED = 10'(SPEED);
  localparam logic [9:0] LP_X_OFF = 10'(X_OFF);
  localparam logic [9:0] LP_Y_OFF = 10'(Y_OFF);

  bullet_state_t     r_state, w_state_next;
  logic [9:0]        r_b_x, w_b_x_next;
  logic [9:0]        r_b_y, w_b_y_next;
  logic              r_en, w_en_next;
  logic              r_shot, w_shot_next;
  logic [COOL_W-1:0] r_cool_cnt, w_cool_next;
  logic              r_fire_q;
  logic              r_rst_d;
  logic              w_fire_edge;
  logic              w_tick;

  // r_rst_d masks the first post-reset cycle, when r_fire_q has not yet
  // caught up with a fire level held through reset.
  assign w_fire_edge = bus.fire && !r_fire_q && !r_rst_d;

  step_ticker #(.DIV(STEP_DIV)) u_step_ticker (
    .clk  (clk),
    .rst  (rst),
    .en   (r_state != IDLE),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_b_x      <= '0;
      r_b_y      <= '0;
      r_en       <= 1'b0;
      r_shot     <= 1'b0;
      r_cool_cnt <= '0;
      r_fire_q   <= 1'b0;
      r_rst_d    <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_b_x      <= w_b_x_next;
      r_b_y      <= w_b_y_next;
      r_en       <= w_en_next;
      r_shot     <= w_shot_next;
      r_cool_cnt <= w_cool_next;
      r_fire_q   <= bus.fire;
      r_rst_d    <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_b_x_next   = r_b_x;
    w_b_y_next   = r_b_y;
    w_en_next    = r_en;
    w_shot_next  = 1'b0;
    w_cool_next  = r_cool_cnt;
    case (r_state)
      IDLE: begin
        if (w_fire_edge) begin
          w_b_x_next   = bus.plane_x + LP_X_OFF;
          w_b_y_next   = sat_sub10(bus.plane_y, LP_Y_OFF);
          w_en_next    = 1'b1;
          w_shot_next  = 1'b1;
          w_state_next = FLY;
        end
      end
      FLY: begin
        // A hit coinciding with a tick retires without moving the bullet.
        if (bus.hit || (w_tick && (r_b_y < LP_SPEED))) begin
          w_en_next    = 1'b0;
          w_cool_next  = '0;
          w_state_next = COOL;
        end else if (w_tick) begin
          w_b_y_next = r_b_y - LP_SPEED;
        end
      end
      COOL: begin
        if (COOLDOWN == 0) begin
          w_state_next = IDLE;
        end else if (w_tick) begin
          if (r_cool_cnt == LP_COOL_LAST) begin
            w_state_next = IDLE;
          end else begin
            w_cool_next = r_cool_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_en_next    = 1'b0;
      end
    endcase
  end

  assign bus.b_x         = r_b_x;
  assign bus.b_y         = r_b_y;
  assign bus.mybullet_en = r_en;
  assign bus.shot        = r_shot;

endmodule

// File: doc/player_bullet_ctrl.md
# player_bullet_ctrl

Owns the single player bullet in the shooter datapath and sits directly upstream of the boss collision judge. It launches a bullet from the player plane on a fire request, steps it up the screen at a fixed rate, and retires it on a hit or when it leaves the top of the screen. Its `b_x`, `b_y` and `mybullet_en` outputs drive the judge's bullet inputs. Its `hit` input comes from the judge's bullet-consumed indication.

## Interface

**Parameters**
- `STEP_DIV`, default 250_000: `clk` cycles per movement step; minimum 2.
- `SPEED`, default 4: pixels moved per step, toward smaller y.
- `X_OFF`, default 14: spawn x offset from `plane_x`.
- `Y_OFF`, default 16: spawn y offset above `plane_y`.
- `COOLDOWN`, default 8: steps after retirement before a new launch is accepted.

**Ports**
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `fire` in 1: fire button level, already debounced.
- `plane_x` in 10: player plane left edge.
- `plane_y` in 10: player plane top edge.
- `hit` in 1: one-cycle pulse meaning the bullet was consumed by a collision.
- `b_x` out 10: bullet x.
- `b_y` out 10: bullet y.
- `mybullet_en` out 1: 1 while a bullet is in flight.
- `shot` out 1: one-cycle pulse on each launch.

## Operation

**State machine:** IDLE → FLY → COOL → IDLE.

**IDLE**
- A rising edge on `fire` launches a bullet. The edge is `fire` high with the registered `fire_q` low.
- On launch:
  - `b_x` ← `plane_x + X_OFF`, truncated to 10 bits.
  - `b_y` ← `plane_y − Y_OFF`, clamped to 0 if `plane_y < Y_OFF`.
  - `mybullet_en` ← 1, `shot` ← 1 for one cycle, state → FLY.
  - The step divider is cleared.
- A held `fire` level never re-launches. A new rising edge is required.

**FLY**
- On each step tick, `b_y` ← `b_y − SPEED`.
- If `b_y < SPEED` at a tick, the bullet leaves the screen instead of moving. `b_y` never wraps.
- Leaving the screen or a `hit` pulse retires the bullet: `mybullet_en` ← 0, state → COOL, cooldown counter cleared.
- `hit` and a tick in the same cycle: `hit` wins and `b_y` is not updated.
- `b_x` is frozen during flight. It does not track the plane.
- `fire` edges are ignored.

**COOL**
- Counts `COOLDOWN` step ticks, then → IDLE.
- `fire` edges are ignored. `hit` is ignored.
- `COOLDOWN` = 0 goes to IDLE on the cycle after retirement.

**Outside FLY:** `b_x` and `b_y` hold their last values.

## Timing

- All outputs are registered.
- `mybullet_en` and `shot` rise one cycle after the `fire` edge cycle, i.e. the cycle after `fire` goes high with `fire_q` low.
- The first movement step occurs `STEP_DIV` cycles after launch.
- On retirement by `hit`, `mybullet_en` falls on the cycle after `hit` is sampled.
- Reset values:
  - `b_x` = 0, `b_y` = 0, `mybullet_en` = 0, `shot` = 0.
  - State = IDLE, `fire_q` = 0, all counters = 0.
- Reset mid-flight kills the bullet immediately, with no cooldown.
- A `fire` level held through reset does not launch, because `fire_q` is loaded from `fire` in the first post-reset cycle.
  - In that first cycle `fire_q` is still 0 from reset, so the launch is blocked by qualifying the edge with a `rst_d` flag that masks that cycle.
- Step divider:
  - 18-bit counter, widened to `$clog2(STEP_DIV)`.
  - Wraps from `STEP_DIV − 1` to 0 and emits the tick on the wrap.
  - Free-running in FLY and COOL; held at 0 in IDLE.

## Structure

- Shared package `game_pkg`:
  - Screen constants `SCREEN_W` = 640 and `SCREEN_H` = 480.
  - The state enum `bullet_state_t` {IDLE, FLY, COOL}.
  - Default `STEP_DIV`.
- One sub-module, `step_ticker`: parameterised divider with `clk`, `rst` and `en` inputs and a `tick` output. It is reused by the enemy-bullet and boss-motion blocks.
- Everything else is flat in `player_bullet_ctrl`.

## Test plan

Use `STEP_DIV` = 4 for all scenarios.

- **Launch:** `plane_x` = 300, `plane_y` = 400, `fire` rising edge → next cycle `b_x` = 314, `b_y` = 384, `mybullet_en` = 1, `shot` high for exactly 1 cycle.
- **Flight and exit:** launch at `b_y` = 384, `SPEED` = 4, no `hit` → `b_y` decreases by 4 every 4 cycles down to 0. The next tick drops `mybullet_en`, and `b_y` stays 0.
- **Hit:** `hit` pulse during FLY coinciding with a tick → `mybullet_en` = 0 the next cycle, `b_y` unchanged, state COOL.
- **Cooldown and held fire:** `fire` held high through flight and cooldown → no relaunch. Release, then press after 8 step ticks of cooldown → launch occurs. A press before the cooldown ends is ignored.
- **Spawn clamp:** `plane_y` = 5, `Y_OFF` = 16 → `b_y` = 0 at launch, exit on the first tick.
- **Reset mid-flight:** `rst` pulse during FLY → all outputs 0. With `fire` held through reset, no launch occurs until a fresh rising edge.
